// File: rtl/cv32e40p_fault_manager.sv
// cv32e40p_fault_manager
//   Collects TMR voter mismatch flags from the hardened EX units and decides
//   whether a fault is transient or permanent. On the first fault it asks for
//   the EX op to be replayed. If the same op keeps faulting for PERM_THRESH
//   attempts, the block escalates: it holds a stall, raises a sticky flag and
//   fires one IRQ pulse. It also keeps a sticky per-source mask and a
//   saturating total-fault counter.
// Ports
//   clk          core clock, rising edge
//   rst          asynchronous active-high reset
//   fault_i      per-source voter mismatch flags
//   ex_ready_i   EX op retires this cycle
//   clear_i      clears status, counter and permanent state (highest priority)
//   stall_o      holds EX/ID while in REPLAY or PERM
//   replay_o     1-cycle re-issue request for the current EX op
//   perm_fault_o sticky permanent-fault flag
//   irq_o        1-cycle pulse on entry to PERM
//   fault_src_o  sticky OR of every source seen faulting
//   fault_cnt_o  saturating count of fault events
module cv32e40p_fault_manager #(
   parameter int NUM_SRC     = 4,
   parameter int CNT_W       = 8,
   parameter int PERM_THRESH = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] fault_i,
   input  logic               ex_ready_i,
   input  logic               clear_i,
   output logic               stall_o,
   output logic               replay_o,
   output logic               perm_fault_o,
   output logic               irq_o,
   output logic [NUM_SRC-1:0] fault_src_o,
   output logic [CNT_W-1:0]   fault_cnt_o
);

   localparam int CW = $clog2(PERM_THRESH + 1);
   localparam logic [CW-1:0] THR = CW'(PERM_THRESH);

   typedef enum logic [1:0] {S_IDLE, S_REPLAY, S_WAIT, S_PERM} state_t;

   state_t             state, state_n;
   logic [CW-1:0]      consec, consec_n;
   logic [NUM_SRC-1:0] src_n;
   logic [CNT_W-1:0]   cnt_n;
   logic               evt;

   // Faults are only meaningful while an op is executing normally; in REPLAY
   // the op is being re-issued and in PERM we are already escalated. A
   // clear in the same cycle discards the fault entirely.
   assign evt = (|fault_i) && ((state == S_IDLE) || (state == S_WAIT)) && !clear_i;

   always_comb begin
      state_n  = state;
      consec_n = consec;
      src_n    = fault_src_o;
      cnt_n    = fault_cnt_o;

      if (evt) begin
         src_n = fault_src_o | fault_i;
         if (!(&fault_cnt_o)) cnt_n = fault_cnt_o + CNT_W'(1);
      end

      case (state)
         S_IDLE: begin
            if (evt) begin
               state_n  = S_REPLAY;
               consec_n = CW'(1);
            end
         end
         S_REPLAY: state_n = S_WAIT;
         S_WAIT: begin
            // A recurring fault beats retirement in the same cycle.
            if (evt) begin
               if ((consec + CW'(1)) == THR) begin
                  state_n = S_PERM;
               end else begin
                  state_n  = S_REPLAY;
                  consec_n = consec + CW'(1);
               end
            end else if (ex_ready_i) begin
               state_n  = S_IDLE;
               consec_n = '0;
            end
         end
         S_PERM:  state_n = S_PERM;
         default: state_n = S_IDLE;
      endcase

      if (clear_i) begin
         state_n  = S_IDLE;
         consec_n = '0;
         src_n    = '0;
         cnt_n    = '0;
      end
   end

   // Outputs are registered from the next-state decode so they line up with
   // the state they describe and carry no combinational path from inputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         consec       <= '0;
         fault_src_o  <= '0;
         fault_cnt_o  <= '0;
         stall_o      <= 1'b0;
         replay_o     <= 1'b0;
         perm_fault_o <= 1'b0;
         irq_o        <= 1'b0;
      end else begin
         state        <= state_n;
         consec       <= consec_n;
         fault_src_o  <= src_n;
         fault_cnt_o  <= cnt_n;
         stall_o      <= (state_n == S_REPLAY) || (state_n == S_PERM);
         replay_o     <= (state_n == S_REPLAY);
         perm_fault_o <= (state_n == S_PERM);
         irq_o        <= (state_n == S_PERM) && (state != S_PERM);
      end
   end

endmodule

// File: tb/tb_cv32e40p_fault_manager.sv
// Scoreboard bench: the stimulus process drives one cycle of inputs and pushes
// the hand-computed outputs expected after the next rising edge; a monitor on
// the falling edge pops and compares. Two DUTs share the stimulus: the default
// one (CNT_W=8) and a CNT_W=2 one for counter saturation.
module tb_cv32e40p_fault_manager;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] fault = '0;
   logic       ex_ready = 1'b0;
   logic       clear = 1'b0;

   logic       stall_a, replay_a, perm_a, irq_a;
   logic [3:0] src_a;
   logic [7:0] cnt_a;
   logic       stall_b, replay_b, perm_b, irq_b;
   logic [3:0] src_b;
   logic [1:0] cnt_b;

   int checks = 0;
   int failures = 0;

   typedef struct {
      string      name;
      logic       stall, replay, perm, irq;
      logic [3:0] src;
      logic [7:0] cnt;
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;

   cv32e40p_fault_manager #(.NUM_SRC(4), .CNT_W(8), .PERM_THRESH(3)) dut_a (
      .clk(clk), .rst(rst), .fault_i(fault), .ex_ready_i(ex_ready), .clear_i(clear),
      .stall_o(stall_a), .replay_o(replay_a), .perm_fault_o(perm_a), .irq_o(irq_a),
      .fault_src_o(src_a), .fault_cnt_o(cnt_a));

   cv32e40p_fault_manager #(.NUM_SRC(4), .CNT_W(2), .PERM_THRESH(3)) dut_b (
      .clk(clk), .rst(rst), .fault_i(fault), .ex_ready_i(ex_ready), .clear_i(clear),
      .stall_o(stall_b), .replay_o(replay_b), .perm_fault_o(perm_b), .irq_o(irq_b),
      .fault_src_o(src_b), .fault_cnt_o(cnt_b));

   // Monitor
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         logic [15:0] ea, aa;
         logic [9:0]  eb, ab;
         logic [1:0]  sat;
         e   = q.pop_front();
         sat = (e.cnt > 8'd3) ? 2'd3 : e.cnt[1:0];
         ea  = {e.stall, e.replay, e.perm, e.irq, e.src, e.cnt};
         aa  = {stall_a, replay_a, perm_a, irq_a, src_a, cnt_a};
         eb  = {e.stall, e.replay, e.perm, e.irq, e.src, sat};
         ab  = {stall_b, replay_b, perm_b, irq_b, src_b, cnt_b};
         checks++;
         if (aa !== ea) begin
            failures++;
            $display("FAIL %s cnt8: got stall/rep/perm/irq/src/cnt=%h want %h", e.name, aa, ea);
         end
         checks++;
         if (ab !== eb) begin
            failures++;
            $display("FAIL %s cnt2: got stall/rep/perm/irq/src/cnt=%h want %h", e.name, ab, eb);
         end
      end
   end

   task automatic st(input string n, input logic [3:0] f, input logic rdy, input logic clr,
                     input logic r, input logic s, input logic rp, input logic p,
                     input logic i, input logic [3:0] src, input logic [7:0] c);
      exp_t e;
      @(negedge clk);
      #1;
      fault = f; ex_ready = rdy; clear = clr; rst = r;
      e.name = n; e.stall = s; e.replay = rp; e.perm = p; e.irq = i; e.src = src; e.cnt = c;
      q.push_back(e);
   endtask

   initial begin
      logic [3:0] srcs [5];
      logic [3:0] acc;
      srcs = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

      // T1 reset with faults asserted, then quiet IDLE
      st("rst_hold0",  4'hF, 0, 0, 1,  0,0,0,0, 4'h0, 8'd0);
      st("rst_hold1",  4'hF, 0, 0, 1,  0,0,0,0, 4'h0, 8'd0);
      st("rst_rel0",   4'h0, 0, 0, 0,  0,0,0,0, 4'h0, 8'd0);
      st("rst_rel1",   4'h0, 0, 0, 0,  0,0,0,0, 4'h0, 8'd0);

      // T2 transient fault recovered by retirement
      st("tr_replay",  4'b0010, 0, 0, 0,  1,1,0,0, 4'b0010, 8'd1);
      st("tr_wait",    4'b0000, 0, 0, 0,  0,0,0,0, 4'b0010, 8'd1);
      st("tr_idle",    4'b0000, 1, 0, 0,  0,0,0,0, 4'b0010, 8'd1);
      st("tr_idle2",   4'b0000, 0, 0, 0,  0,0,0,0, 4'b0010, 8'd1);
      st("clr_idle",   4'b0000, 0, 1, 0,  0,0,0,0, 4'b0000, 8'd0);

      // T3 permanent fault: held flag escalates on the third attempt
      st("pm_replay1", 4'b1000, 0, 0, 0,  1,1,0,0, 4'b1000, 8'd1);
      st("pm_wait1",   4'b1000, 0, 0, 0,  0,0,0,0, 4'b1000, 8'd1);
      st("pm_replay2", 4'b1000, 0, 0, 0,  1,1,0,0, 4'b1000, 8'd2);
      st("pm_wait2",   4'b1000, 0, 0, 0,  0,0,0,0, 4'b1000, 8'd2);
      st("pm_entry",   4'b1000, 0, 0, 0,  1,0,1,1, 4'b1000, 8'd3);
      for (int k = 0; k < 100; k++)
         st("pm_hold", 4'b1000, k[0], 0, 0,  1,0,1,0, 4'b1000, 8'd3);

      // T4 clear out of PERM; fault in the clear cycle is dropped
      st("clr_perm",   4'b0001, 0, 1, 0,  0,0,0,0, 4'b0000, 8'd0);
      st("clr_after",  4'b0000, 0, 0, 0,  0,0,0,0, 4'b0000, 8'd0);

      // T6 fault and retire in the same WAIT cycle: fault wins, consec=2,
      // so one more WAIT fault reaches PERM
      st("race_rep1",  4'b0100, 0, 0, 0,  1,1,0,0, 4'b0100, 8'd1);
      st("race_wait1", 4'b0000, 0, 0, 0,  0,0,0,0, 4'b0100, 8'd1);
      st("race_rep2",  4'b0100, 1, 0, 0,  1,1,0,0, 4'b0100, 8'd2);
      st("race_wait2", 4'b0000, 0, 0, 0,  0,0,0,0, 4'b0100, 8'd2);
      st("race_perm",  4'b0100, 0, 0, 0,  1,0,1,1, 4'b0100, 8'd3);
      st("race_perm2", 4'b0000, 0, 0, 0,  1,0,1,0, 4'b0100, 8'd3);
      st("race_clr",   4'b0000, 0, 1, 0,  0,0,0,0, 4'b0000, 8'd0);

      // T5 five separate transients; the 2-bit counter saturates at 3
      acc = '0;
      for (int k = 0; k < 5; k++) begin
         acc = acc | srcs[k];
         st("sat_replay", srcs[k], 0, 0, 0,  1,1,0,0, acc, 8'(k + 1));
         st("sat_wait",   4'b0000, 0, 0, 0,  0,0,0,0, acc, 8'(k + 1));
         st("sat_idle",   4'b0000, 1, 0, 0,  0,0,0,0, acc, 8'(k + 1));
      end

      // Reset during REPLAY, then no replay pulse after release
      st("rr_replay",  4'b0010, 0, 0, 0,  1,1,0,0, 4'hF, 8'd6);
      st("rr_reset",   4'b0010, 0, 0, 1,  0,0,0,0, 4'h0, 8'd0);
      st("rr_release", 4'b0000, 0, 0, 0,  0,0,0,0, 4'h0, 8'd0);
      st("rr_quiet",   4'b0000, 0, 0, 0,  0,0,0,0, 4'h0, 8'd0);

      repeat (3) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
